// File: rtl/gelato_inst_fetch_mo_pkg.sv
// Shared types for the Gelato SM instruction fetch front end.
//   pc_info_t        : fetch request from the scheduler (pc, warp, split-table entry, thread mask)
//   inst_raw_data_t  : fetched instruction with its request metadata, sent to idecode
//   ifetch_slot_t    : one entry of the fetch ring (metadata, instruction word, filled flag)
//   slot_to_raw()    : formats a ring slot as an idecode word
package gelato_inst_fetch_mo_pkg;

  localparam int PC_W          = 32;
  localparam int INST_RAW_W    = 32;
  localparam int WARP_NUM_W    = 4;
  localparam int SPLIT_NUM_W   = 4;
  localparam int THREAD_MASK_W = 8;

  typedef struct packed {
    logic [PC_W-1:0]          pc;
    logic [WARP_NUM_W-1:0]    warp_num;
    logic [SPLIT_NUM_W-1:0]   split_table_num;
    logic [THREAD_MASK_W-1:0] thread_mask;
  } pc_info_t;

  typedef struct packed {
    logic [PC_W-1:0]          pc;
    logic [WARP_NUM_W-1:0]    warp_num;
    logic [SPLIT_NUM_W-1:0]   split_table_num;
    logic [THREAD_MASK_W-1:0] thread_mask;
    logic [INST_RAW_W-1:0]    inst_raw_data;
  } inst_raw_data_t;

  typedef struct packed {
    pc_info_t              meta;
    logic [INST_RAW_W-1:0] data;
    logic                  filled;
  } ifetch_slot_t;

  function automatic inst_raw_data_t slot_to_raw(input ifetch_slot_t s);
    inst_raw_data_t r;
    r.pc              = s.meta.pc;
    r.warp_num        = s.meta.warp_num;
    r.split_table_num = s.meta.split_table_num;
    r.thread_mask     = s.meta.thread_mask;
    r.inst_raw_data   = s.data;
    return r;
  endfunction

endpackage

// File: rtl/gelato_ifetch_ring.sv
// DEPTH-slot ring of fetch slots with three pointers:
//   alloc_ptr : next slot to receive request metadata (I-Cache read issued)
//   fill_ptr  : next slot to receive I-Cache data (responses return in order)
//   head_ptr  : oldest slot, presented to idecode
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers and filled flags only)
//   en           global enable; low freezes every pointer and slot
//   alloc        write alloc_meta into slot[alloc], mark unfilled, advance alloc_ptr
//   fill         write fill_data into slot[fill], mark filled, advance fill_ptr
//   pop          release slot[head], advance head_ptr
//   clear        drop every slot: head and fill jump to alloc, all filled flags cleared
//   full         DEPTH slots occupied
//   inflight     slots allocated but not yet filled (requests outstanding at the I-Cache)
//   head_slot    contents of slot[head]
module gelato_ifetch_ring
  import gelato_inst_fetch_mo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  alloc,
  input  pc_info_t              alloc_meta,
  input  logic                  fill,
  input  logic [INST_RAW_W-1:0] fill_data,
  input  logic                  pop,
  input  logic                  clear,
  output logic                  full,
  output logic [PW-1:0]         inflight,
  output ifetch_slot_t          head_slot
);

  localparam int IW = $clog2(DEPTH);

  logic [PW-1:0]         alloc_ptr;
  logic [PW-1:0]         fill_ptr;
  logic [PW-1:0]         head_ptr;
  logic [DEPTH-1:0]      filled;
  logic [DEPTH-1:0]      filled_nxt;
  pc_info_t              meta_mem [DEPTH];
  logic [INST_RAW_W-1:0] data_mem [DEPTH];

  logic [IW-1:0] alloc_idx;
  logic [IW-1:0] fill_idx;
  logic [IW-1:0] head_idx;

  assign alloc_idx = alloc_ptr[IW-1:0];
  assign fill_idx  = fill_ptr[IW-1:0];
  assign head_idx  = head_ptr[IW-1:0];

  assign full     = (alloc_ptr - head_ptr) == PW'(DEPTH);
  assign inflight = alloc_ptr - fill_ptr;

  // alloc, fill and pop always address three different slots (empty, pending,
  // filled), so their flag updates never collide.
  always_comb begin
    filled_nxt = filled;
    if (clear) begin
      filled_nxt = '0;
    end else begin
      if (alloc) filled_nxt[alloc_idx] = 1'b0;
      if (fill)  filled_nxt[fill_idx]  = 1'b1;
      if (pop)   filled_nxt[head_idx]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      filled    <= '0;
    end else if (en) begin
      filled <= filled_nxt;
      if (alloc) alloc_ptr <= alloc_ptr + PW'(1);
      if (clear) begin
        fill_ptr <= alloc_ptr;
        head_ptr <= alloc_ptr;
      end else begin
        if (fill) fill_ptr <= fill_ptr + PW'(1);
        if (pop)  head_ptr <= head_ptr + PW'(1);
      end
    end
  end

  // Slot payload needs no reset: it is only observed behind a filled flag.
  always_ff @(posedge clk) begin
    if (en && alloc)          meta_mem[alloc_idx] <= alloc_meta;
    if (en && fill && !clear) data_mem[fill_idx]  <= fill_data;
  end

  always_comb begin
    head_slot.meta   = meta_mem[head_idx];
    head_slot.data   = data_mem[head_idx];
    head_slot.filled = filled[head_idx];
  end

endmodule

// File: rtl/gelato_inst_fetch_mo.sv
// Multi-outstanding instruction fetch unit for the Gelato SM front end.
// Accepts pc_info_t from the fetch scheduler, issues the I-Cache read in the
// same cycle (no skid buffer), and returns instructions to idecode in request
// order through a DEPTH-slot ring. Up to DEPTH fetches in flight or buffered.
// Optional feature macro: GELATO_IFETCH_FLUSH_EN adds the flush port and the
// drain counter that swallows responses to requests issued before a flush.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rdy                global enable; low freezes state and deasserts all valids/readies
//   din_valid/ready/din         scheduler -> fetch handshake (pc_info_t)
//   icache_req_valid/ready/addr read request to the I-Cache (addr = din.pc)
//   icache_rsp_valid/data       in-order read data, no backpressure
//   dout_valid/ready/dout       fetch -> idecode handshake (inst_raw_data_t)
//   flush              (GELATO_IFETCH_FLUSH_EN only) discard every fetch in the unit
module gelato_inst_fetch_mo
  import gelato_inst_fetch_mo_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = PC_W,
  parameter int INST_W = INST_RAW_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              din_valid,
  output logic              din_ready,
  input  pc_info_t          din,
  output logic              icache_req_valid,
  input  logic              icache_req_ready,
  output logic [ADDR_W-1:0] icache_req_addr,
  input  logic              icache_rsp_valid,
  input  logic [INST_W-1:0] icache_rsp_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output inst_raw_data_t    dout
`ifdef GELATO_IFETCH_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic         full;
  logic [PW-1:0] inflight;
  ifetch_slot_t head_slot;
  logic         flush_now;
  logic         draining;
  logic         issue_ok;
  logic         fire;
  logic         fill;
  logic         pop;

`ifdef GELATO_IFETCH_FLUSH_EN
  logic [PW-1:0] drain_cnt;
  logic [PW-1:0] drain_sum;

  assign flush_now = flush;
  assign draining  = (drain_cnt != '0);
  // Responses still owed by the I-Cache after a flush: whatever was already
  // being drained plus everything issued but not yet filled.
  assign drain_sum = drain_cnt + inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (rdy) begin
      if (flush) begin
        // A response landing in the flush cycle is already one of the owed ones.
        drain_cnt <= (icache_rsp_valid && (drain_sum != '0)) ? drain_sum - PW'(1) : drain_sum;
      end else if (draining && icache_rsp_valid) begin
        drain_cnt <= drain_cnt - PW'(1);
      end
    end
  end
`else
  assign flush_now = 1'b0;
  assign draining  = 1'b0;
`endif

  // ---- issue: request and din accept in the same cycle ----
  // A pop does not bypass into issue: full is taken from the registered pointers.
  assign issue_ok         = rst_n & rdy & ~full & ~draining & ~flush_now;
  assign icache_req_valid = issue_ok & din_valid;
  assign din_ready        = issue_ok & icache_req_ready;
  assign icache_req_addr  = ADDR_W'(din.pc);
  assign fire             = din_valid & din_ready;

  // ---- fill: in-order response lands in the oldest pending slot ----
  // A response with nothing pending is illegal and dropped rather than
  // corrupting a free slot.
  assign fill = icache_rsp_valid & ~draining & ~flush_now & (inflight != '0);

  // ---- output: head slot to idecode ----
  assign dout_valid = rdy & head_slot.filled & ~flush_now;
  assign pop        = dout_valid & dout_ready;
  assign dout       = head_slot.filled ? slot_to_raw(head_slot) : '0;

  gelato_ifetch_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (rdy),
    .alloc      (fire),
    .alloc_meta (din),
    .fill       (fill),
    .fill_data  (INST_RAW_W'(icache_rsp_data)),
    .pop        (pop),
    .clear      (flush_now),
    .full       (full),
    .inflight   (inflight),
    .head_slot  (head_slot)
  );

  rsp_has_pending_req: assert property (
    @(posedge clk) disable iff (!rst_n)
    (rdy && icache_rsp_valid && !draining && !flush_now) |-> (inflight != '0)
  );

endmodule
